// File: rtl/snake_pkg.sv
// Shared types and default constants for the snake collision logic.
package snake_pkg;

  localparam int DEF_GRID_W  = 16;
  localparam int DEF_GRID_H  = 16;
  localparam int DEF_MAX_LEN = 16;

  // Collision-scan sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_e;

endpackage

// File: rtl/coord_match.sv
// Coordinate equality: match is high when both x and y are equal.
module coord_match #(
  parameter int N = 4
) (
  input  logic [N-1:0] ax,
  input  logic [N-1:0] ay,
  input  logic [N-1:0] bx,
  input  logic [N-1:0] by,
  output logic         match
);

  assign match = (ax == bx) && (ay == by);

endmodule

// File: rtl/collision_scan.sv
// Collision scan: checks a candidate snake head against the playfield walls
// and against body segments 1..len-1 held in an external registered-read RAM.
module collision_scan
  import snake_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int GRID_W  = DEF_GRID_W,
  parameter  int GRID_H  = DEF_GRID_H,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  head_x,
  input  logic [N-1:0]  head_y,
  input  logic [AW:0]   len,
  output logic [AW-1:0] seg_addr,
  input  logic [N-1:0]  seg_x,
  input  logic [N-1:0]  seg_y,
  output logic          busy,
  output logic          done,
  output logic          hit
);

  scan_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;         // address being issued this cycle
  logic [AW-1:0] last_q, last_d;       // final address to issue (len-1)
  logic [N-1:0]  head_x_q, head_x_d;
  logic [N-1:0]  head_y_q, head_y_d;
  logic          hit_q, hit_d;
  logic          rd_valid_q, rd_valid_d; // seg_x/seg_y carry a requested segment

  logic [AW:0]   len_c;
  logic          wall;
  logic          match;
  logic          hit_now;

  coord_match #(.N(N)) u_match (
    .ax    (head_x_q),
    .ay    (head_y_q),
    .bx    (seg_x),
    .by    (seg_y),
    .match (match)
  );

  assign len_c   = (len > (AW+1)'(MAX_LEN)) ? (AW+1)'(MAX_LEN) : len;
  assign wall    = (32'(head_x) >= 32'(GRID_W)) || (32'(head_y) >= 32'(GRID_H));
  assign hit_now = rd_valid_q && match;

  // Outputs; an address is withheld in the cycle a match is seen.
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hit      = hit_q;
  assign seg_addr = (state_q == SCAN && !hit_now) ? idx_q : '0;

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    head_x_d   = head_x_q;
    head_y_d   = head_y_q;
    hit_d      = hit_q;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          head_x_d = head_x;
          head_y_d = head_y;
          last_d   = AW'(len_c - (AW+1)'(1));
          idx_d    = AW'(1);
          hit_d    = 1'b0;
          if (wall) begin
            hit_d   = 1'b1;
            state_d = DONE;
          end else if (len_c <= (AW+1)'(1)) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (hit_now) begin
          hit_d   = 1'b1;
          state_d = DONE;
        end else begin
          rd_valid_d = 1'b1;
          if (idx_q == last_q) begin
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      DRAIN: begin
        if (hit_now) begin
          hit_d = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      head_x_q   <= '0;
      head_y_q   <= '0;
      hit_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      head_x_q   <= head_x_d;
      head_y_q   <= head_y_d;
      hit_q      <= hit_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_collision_scan.sv
// Self-checking bench for collision_scan with a registered-read segment RAM.
module tb_collision_scan;

  localparam int N       = 5;
  localparam int MAX_LEN = 16;
  localparam int GRID_W  = 16;
  localparam int GRID_H  = 16;
  localparam int AW      = 4;
  localparam int WINDOW  = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  head_x = '0;
  logic [N-1:0]  head_y = '0;
  logic [AW:0]   len = '0;
  logic [AW-1:0] seg_addr;
  logic [N-1:0]  seg_x = '0;
  logic [N-1:0]  seg_y = '0;
  logic          busy, done, hit;

  logic [N-1:0]  mem_x [MAX_LEN];
  logic [N-1:0]  mem_y [MAX_LEN];

  int checks = 0;
  int errors = 0;

  // Observations from the most recent scan.
  int   obs_addrs[$];
  int   obs_done_cyc;
  int   obs_n_done;
  logic obs_hit_done;
  logic obs_hit_end;

  collision_scan #(
    .N(N), .MAX_LEN(MAX_LEN), .GRID_W(GRID_W), .GRID_H(GRID_H)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .head_x(head_x), .head_y(head_y), .len(len),
    .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
    .busy(busy), .done(done), .hit(hit)
  );

  always #5 clk = ~clk;

  // External segment RAM: one-cycle registered read.
  always @(posedge clk) begin
    seg_x <= mem_x[seg_addr];
    seg_y <= mem_y[seg_addr];
  end

  // Launch a scan and watch a fixed window; optionally pulse start again
  // with different inputs in cycle poke_cyc.
  task automatic do_scan(input int hx, input int hy, input int ln,
                         input int poke_cyc, input int phx, input int phy, input int pln);
    obs_addrs.delete();
    obs_done_cyc = -1;
    obs_n_done   = 0;
    obs_hit_done = 1'bx;
    @(negedge clk);
    head_x = N'(hx); head_y = N'(hy); len = (AW+1)'(ln); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= WINDOW; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (seg_addr != '0) obs_addrs.push_back(int'(seg_addr));
      if (done) begin
        obs_n_done++;
        if (obs_done_cyc < 0) begin
          obs_done_cyc = c;
          obs_hit_done = hit;
        end
      end
      if (c == poke_cyc) begin
        head_x = N'(phx); head_y = N'(phy); len = (AW+1)'(pln); start = 1'b1;
      end
    end
    obs_hit_end = hit;
    $display("scan head=(%0d,%0d) len=%0d -> done_cyc=%0d dones=%0d hit=%0b reads=%0d",
             hx, hy, ln, obs_done_cyc, obs_n_done, obs_hit_done, obs_addrs.size());
  endtask

  // Reference: walk the body from index 1 upward looking for the head.
  function automatic void model(input int hx, input int hy, input int ln,
                                output int e_done, output logic e_hit, output int e_nread);
    int l;
    l = (ln > MAX_LEN) ? MAX_LEN : ln;
    e_hit = 1'b0; e_nread = 0; e_done = 1;
    if (hx >= GRID_W || hy >= GRID_H) begin
      e_hit = 1'b1;
    end else if (l >= 2) begin
      e_done = l + 1;
      e_nread = l - 1;
      for (int i = 1; i < l; i++) begin
        if (int'(mem_x[i]) == hx && int'(mem_y[i]) == hy) begin
          e_hit = 1'b1; e_done = i + 2; e_nread = i;
          break;
        end
      end
    end
  endfunction

  task automatic fill_body(input int px, input int py);
    for (int i = 0; i < MAX_LEN; i++) begin
      mem_x[i] = N'(px); mem_y[i] = N'(py);
    end
    mem_x[0] = 5'd3; mem_y[0] = 5'd3;
    mem_x[1] = 5'd3; mem_y[1] = 5'd4;
    mem_x[2] = 5'd3; mem_y[2] = 5'd5;
    mem_x[3] = 5'd4; mem_y[3] = 5'd5;
    mem_x[4] = 5'd5; mem_y[4] = 5'd5;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b want=0", hit); end
    checks++; if (seg_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d want=0", seg_addr); end
    rst = 1'b0;
  endtask

  task automatic test_no_hit();
    fill_body(9, 9);
    do_scan(3, 3, 5, 0, 0, 0, 0);
    checks++; if (obs_done_cyc != 6) begin errors++; $display("FAIL nohit_cycle got=%0d want=6", obs_done_cyc); end
    checks++; if (obs_hit_done !== 1'b0) begin errors++; $display("FAIL nohit_hit got=%b want=0", obs_hit_done); end
    checks++; if (obs_addrs.size() != 4) begin errors++; $display("FAIL nohit_nreads got=%0d want=4", obs_addrs.size()); end
    for (int i = 0; i < obs_addrs.size() && i < 4; i++) begin
      checks++; if (obs_addrs[i] != i + 1) begin errors++; $display("FAIL nohit_addr got=%0d want=%0d", obs_addrs[i], i + 1); end
    end
  endtask

  task automatic test_hit();
    fill_body(9, 9);
    do_scan(3, 5, 5, 0, 0, 0, 0);
    checks++; if (obs_done_cyc != 4) begin errors++; $display("FAIL hit_cycle got=%0d want=4", obs_done_cyc); end
    checks++; if (obs_hit_done !== 1'b1) begin errors++; $display("FAIL hit_hit got=%b want=1", obs_hit_done); end
    checks++; if (obs_addrs.size() != 2) begin errors++; $display("FAIL hit_nreads got=%0d want=2", obs_addrs.size()); end
    checks++; if (obs_hit_end !== 1'b1) begin errors++; $display("FAIL hit_held got=%b want=1", obs_hit_end); end
    checks++; if (obs_n_done != 1) begin errors++; $display("FAIL hit_ndone got=%0d want=1", obs_n_done); end
  endtask

  task automatic test_wall();
    do_scan(16, 2, 5, 0, 0, 0, 0);
    checks++; if (obs_done_cyc != 1) begin errors++; $display("FAIL wall_cycle got=%0d want=1", obs_done_cyc); end
    checks++; if (obs_hit_done !== 1'b1) begin errors++; $display("FAIL wall_hit got=%b want=1", obs_hit_done); end
    checks++; if (obs_addrs.size() != 0) begin errors++; $display("FAIL wall_nreads got=%0d want=0", obs_addrs.size()); end
    do_scan(2, 17, 5, 0, 0, 0, 0);
    checks++; if (obs_hit_done !== 1'b1 || obs_done_cyc != 1) begin
      errors++; $display("FAIL wall_y got hit=%b cyc=%0d want hit=1 cyc=1", obs_hit_done, obs_done_cyc);
    end
  endtask

  task automatic test_short_and_busy();
    fill_body(9, 9);
    do_scan(3, 3, 1, 0, 0, 0, 0);
    checks++; if (obs_done_cyc != 1) begin errors++; $display("FAIL short_cycle got=%0d want=1", obs_done_cyc); end
    checks++; if (obs_hit_done !== 1'b0) begin errors++; $display("FAIL short_hit got=%b want=0", obs_hit_done); end
    checks++; if (obs_addrs.size() != 0) begin errors++; $display("FAIL short_nreads got=%0d want=0", obs_addrs.size()); end
    // Second start mid-scan would hit at index 1 if it were latched.
    do_scan(3, 3, 8, 3, 3, 4, 2);
    checks++; if (obs_n_done != 1) begin errors++; $display("FAIL busy_ndone got=%0d want=1", obs_n_done); end
    checks++; if (obs_done_cyc != 9) begin errors++; $display("FAIL busy_cycle got=%0d want=9", obs_done_cyc); end
    checks++; if (obs_hit_done !== 1'b0) begin errors++; $display("FAIL busy_hit got=%b want=0", obs_hit_done); end
    checks++; if (obs_addrs.size() != 7) begin errors++; $display("FAIL busy_nreads got=%0d want=7", obs_addrs.size()); end
  endtask

  task automatic test_reset_midscan();
    int n_done;
    fill_body(9, 9);
    n_done = 0;
    @(negedge clk);
    head_x = 5'd3; head_y = 5'd3; len = 5'd8; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    checks++; if (busy !== 1'b1 || seg_addr !== 4'd3) begin
      errors++; $display("FAIL midscan_active got busy=%b addr=%0d want busy=1 addr=3", busy, seg_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({busy, done, hit, seg_addr} !== '0) begin
      errors++; $display("FAIL midscan_reset got busy=%b done=%b hit=%b addr=%0d want all 0", busy, done, hit, seg_addr);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    $display("reset mid-scan -> dones after reset=%0d", n_done);
    checks++; if (n_done != 0) begin errors++; $display("FAIL midscan_nodone got=%0d want=0", n_done); end
  endtask

  task automatic test_start_with_rst();
    int n_done;
    n_done = 0;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; head_x = 5'd20; head_y = 5'd1; len = 5'd3;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rststart_busy got=%b want=0", busy); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    $display("start with rst -> dones=%0d", n_done);
    checks++; if (n_done != 0) begin errors++; $display("FAIL rststart_nodone got=%0d want=0", n_done); end
  endtask

  task automatic test_max_len();
    fill_body(9, 9);
    do_scan(1, 1, 16, 0, 0, 0, 0);
    checks++; if (obs_done_cyc != 17) begin errors++; $display("FAIL maxlen_cycle got=%0d want=17", obs_done_cyc); end
    checks++; if (obs_hit_done !== 1'b0) begin errors++; $display("FAIL maxlen_hit got=%b want=0", obs_hit_done); end
    checks++; if (obs_addrs.size() != 15 || obs_addrs[14] != 15) begin
      errors++; $display("FAIL maxlen_addrs got n=%0d want n=15 ending at 15", obs_addrs.size());
    end
    // len above MAX_LEN behaves exactly as MAX_LEN.
    do_scan(1, 1, 20, 0, 0, 0, 0);
    checks++; if (obs_done_cyc != 17 || obs_addrs.size() != 15) begin
      errors++; $display("FAIL clamp got cyc=%0d n=%0d want cyc=17 n=15", obs_done_cyc, obs_addrs.size());
    end
  endtask

  task automatic test_random();
    int hx, hy, ln, e_done, e_nread;
    logic e_hit;
    bit ok;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_x[i] = N'($urandom_range(0, 3));
        mem_y[i] = N'($urandom_range(0, 3));
      end
      hx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 3));
      hy = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 31)) : int'($urandom_range(0, 3));
      ln = $urandom_range(0, 20);
      model(hx, hy, ln, e_done, e_hit, e_nread);
      do_scan(hx, hy, ln, 0, 0, 0, 0);
      ok = (obs_done_cyc == e_done) && (obs_hit_done === e_hit) && (obs_n_done == 1)
           && (obs_addrs.size() == e_nread) && (obs_hit_end === e_hit);
      for (int i = 0; i < obs_addrs.size(); i++) if (obs_addrs[i] != i + 1) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL random_%0d got cyc=%0d hit=%b dones=%0d reads=%0d want cyc=%0d hit=%b dones=1 reads=%0d",
                 t, obs_done_cyc, obs_hit_done, obs_n_done, obs_addrs.size(), e_done, e_hit, e_nread);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MAX_LEN; i++) begin
      mem_x[i] = '0; mem_y[i] = '0;
    end
    test_reset();
    test_no_hit();
    test_hit();
    test_wall();
    test_short_and_busy();
    test_reset_midscan();
    test_start_with_rst();
    test_max_len();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/collision_scan.md
COLLISION_SCAN -- requirements
Module: collision_scan

Interface
REQ-001 SHALL have parameter N, default 4: coordinate width in bits.
REQ-002 SHALL have parameter MAX_LEN, default 16: maximum snake segments; index width AW = $clog2(MAX_LEN).
REQ-003 SHALL have parameter GRID_W, default 16: playfield width in cells.
REQ-004 SHALL have parameter GRID_H, default 16: playfield height in cells.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: request a collision check; sampled only in IDLE.
REQ-008 SHALL have port head_x, input, N: candidate head column.
REQ-009 SHALL have port head_y, input, N: candidate head row.
REQ-010 SHALL have port len, input, AW+1: current snake length, including the head.
REQ-011 SHALL have port seg_addr, output, AW: body-segment read index.
REQ-012 SHALL have port seg_x, input, N: segment column; valid 1 cycle after seg_addr.
REQ-013 SHALL have port seg_y, input, N: segment row; valid 1 cycle after seg_addr.
REQ-014 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-015 SHALL have port done, output, 1: single-cycle result-valid pulse.
REQ-016 SHALL have port hit, output, 1: collision result; held stable until the next accepted start.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN, DRAIN, DONE.
REQ-018 In IDLE with start=1, SHALL latch head_x, head_y and len, clear hit, and leave IDLE on the same edge.
REQ-019 Wall check: if latched head_x >= GRID_W or head_y >= GRID_H, SHALL go IDLE->DONE with hit=1 and issue no reads.
REQ-020 If len <= 1 and there is no wall hit, SHALL go IDLE->DONE with hit=0 and issue no reads.
REQ-021 Otherwise SHALL enter SCAN and issue seg_addr = 1, 2, ... len-1, one per cycle; segment 0 (the old head) is never read.
REQ-022 SHALL compare each returned segment one cycle after its address, using an equality match on both x and y.
REQ-023 After issuing address len-1, SHALL enter DRAIN for one cycle to consume the final read.
REQ-024 On the first match, SHALL set hit=1, stop issuing addresses, discard any in-flight read, and go to DONE on the next edge.
REQ-025 done SHALL be high for exactly one cycle while in DONE; DONE SHALL return to IDLE unconditionally.
REQ-026 Latency, no hit, len=L>=2: done SHALL be high in cycle L+1 after the start edge.
REQ-027 Latency, first match at index i: done SHALL be high in cycle i+2.
REQ-028 Latency, wall hit or len<=1: done SHALL be high in cycle 1.
REQ-029 start while busy SHALL be ignored; it is neither queued nor allowed to alter the latched inputs.
REQ-030 len > MAX_LEN SHALL be clamped to MAX_LEN.
REQ-031 seg_addr SHALL be 0 outside SCAN.
REQ-032 Index counter SHALL be AW bits wide and SHALL not wrap: the last issued index is len-1 <= MAX_LEN-1.

Reset
REQ-033 rst=1 SHALL force IDLE and busy=0, done=0, hit=0, seg_addr=0 on the next edge, including mid-SCAN.
REQ-034 A reset mid-scan SHALL produce no done pulse.
REQ-035 A start sampled in the same cycle as rst SHALL be ignored.

Structure
REQ-036 The state enum and default GRID_W/GRID_H/MAX_LEN constants SHALL live in the shared package snake_pkg.
REQ-037 Equality compare SHALL be one sub-module, coord_match (N-bit x and y equality -> match), instantiated once.
REQ-038 Segment storage SHALL be external; this block only sequences reads.

Verification
REQ-039 start, head=(3,3), len=5, body (3,4),(3,5),(4,5),(5,5) -> addrs 1..4, done in cycle 6, hit=0.
REQ-040 start, head=(3,5), len=5, same body -> match at index 2, done in cycle 4, hit=1, addr 3 not issued.
REQ-041 start, head=(16,2) -> no reads, done in cycle 1, hit=1.
REQ-042 start, len=1 -> done in cycle 1, hit=0; start pulsed again during a len=8 scan -> ignored, single done.
REQ-043 rst asserted in cycle 3 of a len=8 scan -> next cycle IDLE with all outputs 0; no done pulse follows.
REQ-044 len=MAX_LEN=16 with no match -> addrs 1..15, done in cycle 17, index counter never wraps.
